// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder
// Far-end responder for the Ibex req/gnt/rvalid bus. Grants requests,
// performs byte-masked writes into a local word array, and returns
// read data with inverted SECDED (39,32) check bits after a fixed latency.
// Out-of-range accesses and writes with bad integrity return an error.

module ibex_mem_responder #(
   parameter logic [31:0] BaseAddr       = 32'h0010_0000,
   parameter int unsigned MemSizeBytes   = 65536,
   parameter int unsigned RespLatency    = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [6:0]  wdata_intg_i,
   input  logic        stall_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic [6:0]  rdata_intg_o,
   output logic        err_o
);

   localparam int unsigned NumWords = MemSizeBytes / 4;
   localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
   // Check bits of an all-zero word under the inverted code.
   localparam logic [6:0]  IntgZero = 7'h2A;
   localparam logic [3:0]  MaxOut   = 4'(MaxOutstanding);

   // Inverted SECDED (39,32) check-bit generator, bit-compatible with
   // prim_secded_inv_39_32_enc.
   function automatic logic [6:0] secded_inv_39_32_enc(input logic [31:0] data);
      logic [6:0] chk;
      chk[0] = ^(data & 32'h2606_BD25);
      chk[1] = ^(data & 32'hDEBA_8050);
      chk[2] = ^(data & 32'h413D_89AA);
      chk[3] = ^(data & 32'h3123_4ED1);
      chk[4] = ^(data & 32'hC2C1_323B);
      chk[5] = ^(data & 32'h2DCC_624C);
      chk[6] = ^(data & 32'h9850_5586);
      return chk ^ 7'h2A;
   endfunction

   // Word storage; intentionally not reset.
   logic [31:0] mem [NumWords];

   // Address decode and request qualification.
   logic [31:0]     offset;
   logic            above_base;
   logic            in_range;
   logic [IdxW-1:0] word_idx;
   logic            intg_ok;
   logic            wr_en;
   logic            unused_offset_bits;

   // Outstanding-grant bookkeeping.
   logic [3:0] outstanding_q;
   logic [3:0] outstanding_d;

   // Response computed for the request being granted this cycle.
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] stage0_rdata;
   logic [6:0]  stage0_intg;
   logic        stage0_err;

   // Response pipeline, stage RespLatency-1 drives the outputs.
   logic [RespLatency-1:0] pipe_valid;
   logic [RespLatency-1:0] pipe_err;
   logic [31:0]            pipe_rdata [RespLatency];
   logic [6:0]             pipe_intg  [RespLatency];

   // Offset is computed by subtraction so BaseAddr+MemSizeBytes never overflows.
   assign offset     = addr_i - BaseAddr;
   assign above_base = (addr_i >= BaseAddr);
   assign in_range   = above_base && (offset < 32'(MemSizeBytes));
   assign word_idx   = (NumWords > 1) ? offset[IdxW+1:2] : {IdxW{1'b0}};
   assign intg_ok    = (wdata_intg_i == secded_inv_39_32_enc(wdata_i));

   // Byte-offset bits and bits above the array size never select a word.
   assign unused_offset_bits = ^{offset[31:IdxW+2], offset[1:0]};

   // The grant uses the registered count, before any same-cycle retirement.
   assign gnt_o = req_i & ~stall_i & (outstanding_q < MaxOut);

   // Array writes only happen for clean, in-range, granted writes outside reset.
   assign wr_en = gnt_o & we_i & in_range & intg_ok & rst_ni;

   // Byte-masked array update at the grant edge.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
               mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   // Classify the request: error flag and returned data (zero unless a good read).
   always_comb begin
      resp_err   = 1'b0;
      resp_rdata = 32'd0;
      if (!in_range) begin
         resp_err   = 1'b1;
         resp_rdata = 32'd0;
      end else if (we_i) begin
         resp_err   = ~intg_ok;
         resp_rdata = 32'd0;
      end else begin
         resp_err   = 1'b0;
         resp_rdata = mem[word_idx];
      end
   end

   // Idle pipeline slots carry zero data so the outputs rest at reset values.
   always_comb begin
      stage0_err   = 1'b0;
      stage0_rdata = 32'd0;
      if (gnt_o) begin
         stage0_err   = resp_err;
         stage0_rdata = resp_rdata;
      end else begin
         stage0_err   = 1'b0;
         stage0_rdata = 32'd0;
      end
      stage0_intg = secded_inv_39_32_enc(stage0_rdata);
   end

   // Response shift register: load stage 0 on the grant edge, shift toward the outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_valid <= {RespLatency{1'b0}};
         pipe_err   <= {RespLatency{1'b0}};
         for (int s = 0; s < RespLatency; s++) begin
            pipe_rdata[s] <= 32'd0;
            pipe_intg[s]  <= IntgZero;
         end
      end else begin
         pipe_valid[0] <= gnt_o;
         pipe_err[0]   <= stage0_err;
         pipe_rdata[0] <= stage0_rdata;
         pipe_intg[0]  <= stage0_intg;
         for (int s = 1; s < RespLatency; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_err[s]   <= pipe_err[s-1];
            pipe_rdata[s] <= pipe_rdata[s-1];
            pipe_intg[s]  <= pipe_intg[s-1];
         end
      end
   end

   assign rvalid_o     = pipe_valid[RespLatency-1];
   assign err_o        = pipe_err[RespLatency-1];
   assign rdata_o      = pipe_rdata[RespLatency-1];
   assign rdata_intg_o = pipe_intg[RespLatency-1];

   // Next outstanding count: grant adds one, a response cycle removes one.
   always_comb begin
      outstanding_d = outstanding_q;
      if (gnt_o && !rvalid_o) begin
         outstanding_d = outstanding_q + 4'd1;
      end else if (!gnt_o && rvalid_o) begin
         outstanding_d = outstanding_q - 4'd1;
      end else begin
         outstanding_d = outstanding_q;
      end
   end

   // Outstanding count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= 4'd0;
      end else begin
         outstanding_q <= outstanding_d;
      end
   end

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed testbench for ibex_mem_responder.
// Instance a: RespLatency=2, MaxOutstanding=2. Instance b: RespLatency=2,
// MaxOutstanding=3. Both share the request inputs and are observed separately.

module tb_ibex_mem_responder;

   localparam logic [31:0] Base    = 32'h0010_0000;
   localparam int unsigned MemSize = 65536;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [6:0]  wintg;
   logic        stall;

   logic        a_gnt, a_rvalid, a_err;
   logic [31:0] a_rdata;
   logic [6:0]  a_rintg;
   logic        b_gnt, b_rvalid, b_err;
   logic [31:0] b_rdata;
   logic [6:0]  b_rintg;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ibex_mem_responder #(
      .BaseAddr(Base), .MemSizeBytes(MemSize), .RespLatency(2), .MaxOutstanding(2)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(a_gnt), .we_i(we), .be_i(be),
      .addr_i(addr), .wdata_i(wdata), .wdata_intg_i(wintg), .stall_i(stall),
      .rvalid_o(a_rvalid), .rdata_o(a_rdata), .rdata_intg_o(a_rintg), .err_o(a_err)
   );

   ibex_mem_responder #(
      .BaseAddr(Base), .MemSizeBytes(MemSize), .RespLatency(2), .MaxOutstanding(3)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(b_gnt), .we_i(we), .be_i(be),
      .addr_i(addr), .wdata_i(wdata), .wdata_intg_i(wintg), .stall_i(stall),
      .rvalid_o(b_rvalid), .rdata_o(b_rdata), .rdata_intg_o(b_rintg), .err_o(b_err)
   );

   // Reference inverted SECDED (39,32) encoder.
   function automatic logic [6:0] ref_intg(input logic [31:0] d);
      logic [6:0] c;
      c[0] = ^(d & 32'h2606BD25);
      c[1] = ^(d & 32'hDEBA8050);
      c[2] = ^(d & 32'h413D89AA);
      c[3] = ^(d & 32'h31234ED1);
      c[4] = ^(d & 32'hC2C1323B);
      c[5] = ^(d & 32'h2DCC624C);
      c[6] = ^(d & 32'h98505586);
      return c ^ 7'h2A;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   // Wait (bounded) for instance a's response after a grant edge; start at posedge+1.
   task automatic wait_resp(output int lat, output logic [31:0] rd, output logic [6:0] ri,
                            output logic er);
      lat = 0; rd = 32'd0; ri = 7'd0; er = 1'b0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         if (a_rvalid) begin
            lat = c; rd = a_rdata; ri = a_rintg; er = a_err;
         end
      end
      if (lat == 0) lat = 99;
      @(negedge clk);
      check("rvalid_one_cycle", {31'd0, a_rvalid}, 32'd0);
      @(posedge clk); #1;
   endtask

   // One transaction on an idle bus; expects a zero-cycle grant.
   task automatic txn(input logic t_we, input logic [3:0] t_be, input logic [31:0] t_addr,
                      input logic [31:0] t_wdata, input logic [6:0] t_intg,
                      output int lat, output logic [31:0] rd, output logic [6:0] ri,
                      output logic er);
      int waitc;
      waitc = 0;
      req = 1'b1; we = t_we; be = t_be; addr = t_addr; wdata = t_wdata; wintg = t_intg;
      @(negedge clk);
      check("zero_cycle_gnt", {31'd0, a_gnt}, 32'd1);
      while (!a_gnt && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0; wdata = 32'd0; wintg = 7'd0;
      wait_resp(lat, rd, ri, er);
   endtask

   // Six reads of Base+4 with req held high; observe instance a (sel=0) or b (sel=1).
   task automatic burst(input bit sel, input logic [31:0] exp_pat, input string nm);
      int          q[$];
      int          cyc, grants, rv, maxo, pend, front;
      logic        g, v;
      logic [31:0] d;
      logic [31:0] pat;
      cyc = 0; grants = 0; rv = 0; maxo = 0; pat = 32'd0;
      req = 1'b1; we = 1'b0; be = 4'hF; addr = Base + 32'd4;
      while ((grants < 6 || rv < 6) && cyc < 40) begin
         @(negedge clk);
         pend = grants - rv;
         if (pend > maxo) maxo = pend;
         g = sel ? b_gnt : a_gnt;
         v = sel ? b_rvalid : a_rvalid;
         d = sel ? b_rdata : a_rdata;
         if (g && req) begin
            q.push_back(cyc);
            grants++;
            if (cyc < 32) pat[cyc] = 1'b1;
         end
         if (v) begin
            if (q.size() == 0) begin
               check({nm, "_spurious_rvalid"}, 32'd1, 32'd0);
            end else begin
               front = q.pop_front();
               check({nm, "_order"}, 32'(cyc), 32'(front + 2));
            end
            check({nm, "_rdata"}, d, 32'hDEADBEEF);
            rv++;
         end
         @(posedge clk); #1;
         if (grants >= 6) req = 1'b0;
         cyc++;
      end
      req = 1'b0;
      check({nm, "_gnt_pattern"}, pat, exp_pat);
      check({nm, "_grants"}, 32'(grants), 32'd6);
      check({nm, "_rvalids"}, 32'(rv), 32'd6);
      check({nm, "_max_outstanding"}, 32'(maxo), 32'd2);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat, seen;
      logic [31:0] rd;
      logic [6:0]  ri;
      logic        er;

      rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'd0;
      wdata = 32'd0; wintg = 7'd0; stall = 1'b0;

      // Reset values.
      @(negedge clk);
      check("rst_rvalid", {31'd0, a_rvalid}, 32'd0);
      check("rst_err", {31'd0, a_err}, 32'd0);
      check("rst_rdata", a_rdata, 32'd0);
      check("rst_rintg", {25'd0, a_rintg}, 32'h2A);
      check("rst_gnt_idle", {31'd0, a_gnt}, 32'd0);
      req = 1'b1;
      #1;
      check("rst_gnt_eq", {31'd0, a_gnt}, 32'd1);
      req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic write then read.
      txn(1'b1, 4'hF, Base + 32'd4, 32'hDEADBEEF, ref_intg(32'hDEADBEEF), lat, rd, ri, er);
      check("wr_latency", 32'(lat), 32'd2);
      check("wr_err", {31'd0, er}, 32'd0);
      check("wr_rdata", rd, 32'd0);
      check("wr_rintg", {25'd0, ri}, 32'h2A);
      txn(1'b0, 4'hF, Base + 32'd4, 32'd0, 7'd0, lat, rd, ri, er);
      check("rd_latency", 32'(lat), 32'd2);
      check("rd_rdata", rd, 32'hDEADBEEF);
      check("rd_rintg", {25'd0, ri}, {25'd0, ref_intg(32'hDEADBEEF)});
      check("rd_err", {31'd0, er}, 32'd0);

      // Byte masking.
      txn(1'b1, 4'hF, Base + 32'd8, 32'h11223344, ref_intg(32'h11223344), lat, rd, ri, er);
      txn(1'b1, 4'b0101, Base + 32'd8, 32'hAABBCCDD, ref_intg(32'hAABBCCDD), lat, rd, ri, er);
      check("mask_wr_err", {31'd0, er}, 32'd0);
      txn(1'b0, 4'h0, Base + 32'd8, 32'd0, 7'd0, lat, rd, ri, er);
      check("mask_rdata", rd, 32'h11BB33DD);
      check("mask_rintg", {25'd0, ri}, {25'd0, ref_intg(32'h11BB33DD)});

      // Out-of-range reads, both ends.
      txn(1'b0, 4'hF, Base + 32'(MemSize), 32'd0, 7'd0, lat, rd, ri, er);
      check("oor_hi_err", {31'd0, er}, 32'd1);
      check("oor_hi_rdata", rd, 32'd0);
      check("oor_hi_rintg", {25'd0, ri}, 32'h2A);
      check("oor_hi_latency", 32'(lat), 32'd2);
      txn(1'b0, 4'hF, Base - 32'd4, 32'd0, 7'd0, lat, rd, ri, er);
      check("oor_lo_err", {31'd0, er}, 32'd1);
      txn(1'b0, 4'hF, Base + 32'(MemSize) - 32'd4, 32'd0, 7'd0, lat, rd, ri, er);
      check("last_word_err", {31'd0, er}, 32'd0);

      // Integrity-failing write leaves the word unchanged.
      txn(1'b1, 4'hF, Base + 32'd8, 32'h55AA55AA, ref_intg(32'h55AA55AA) ^ 7'h01,
          lat, rd, ri, er);
      check("bad_intg_err", {31'd0, er}, 32'd1);
      check("bad_intg_rdata", rd, 32'd0);
      txn(1'b0, 4'hF, Base + 32'd8, 32'd0, 7'd0, lat, rd, ri, er);
      check("bad_intg_unchanged", rd, 32'h11BB33DD);

      // Stall hook.
      stall = 1'b1; req = 1'b1; we = 1'b0; be = 4'hF; addr = Base + 32'd8;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_gnt_low", {31'd0, a_gnt}, 32'd0);
         @(posedge clk); #1;
      end
      stall = 1'b0;
      @(negedge clk);
      check("stall_drop_gnt", {31'd0, a_gnt}, 32'd1);
      @(posedge clk); #1;
      req = 1'b0;
      wait_resp(lat, rd, ri, er);
      check("stall_latency", 32'(lat), 32'd2);
      check("stall_rdata", rd, 32'h11BB33DD);

      // Throughput and back-pressure.
      burst(1'b0, 32'h0000_00DB, "tp_max2");
      burst(1'b1, 32'h0000_003F, "tp_max3");

      // Reset mid-flight.
      req = 1'b1; we = 1'b0; be = 4'hF; addr = Base + 32'd4;
      @(negedge clk);
      check("midrst_gnt", {31'd0, a_gnt}, 32'd1);
      @(posedge clk); #1;
      req = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_rvalid", {31'd0, a_rvalid}, 32'd0);
      check("midrst_rintg", {25'd0, a_rintg}, 32'h2A);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (a_rvalid || b_rvalid) seen++;
      end
      check("midrst_no_stale", 32'(seen), 32'd0);
      check("midrst_rdata", a_rdata, 32'd0);
      check("midrst_err", {31'd0, a_err}, 32'd0);
      @(posedge clk); #1;
      txn(1'b0, 4'hF, Base + 32'd4, 32'd0, 7'd0, lat, rd, ri, er);
      check("post_rst_latency", 32'(lat), 32'd2);
      check("post_rst_rdata", rd, 32'hDEADBEEF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ibex_mem_responder.md
# ibex_mem_responder

Single-port memory responder for the Ibex instruction or data bus: it sits at the far end of the `req/gnt/rvalid` interface that the core drives. It grants requests, performs byte-masked writes into a local word array, and returns read data with 7-bit integrity after a fixed latency. Errors are signalled for out-of-range or integrity-failing accesses. One instance serves the instruction port (writes tied off) and another the data port in simulation and FPGA tops.

## Interface
- `BaseAddr`, default 32'h0010_0000: first byte address served.
- `MemSizeBytes`, default 65536: size in bytes; power of two, ≥4.
- `RespLatency`, default 1: cycles from grant to `rvalid_o`; range 1..8.
- `MaxOutstanding`, default 2: granted-but-unanswered limit; range 1..`RespLatency`+1.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  request accepted this cycle.
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  4  byte enables.
- `addr_i`  in  32  byte address; bits [1:0] ignored.
- `wdata_i`  in  32  write data.
- `wdata_intg_i`  in  7  write-data integrity.
- `stall_i`  in  1  test hook; forces `gnt_o` low.
- `rvalid_o`  out  1  response valid, one cycle per grant.
- `rdata_o`  out  32  read data.
- `rdata_intg_o`  out  7  integrity of `rdata_o`.
- `err_o`  out  1  error response; qualified by `rvalid_o`.

## Operation
- Integrity code: the 7 check bits of the inverted SECDED (39,32) encoding, identical to the prim_secded_inv_39_32 encoder.
- Grant: `gnt_o = req_i & ~stall_i & (outstanding < MaxOutstanding)`. This is combinational. `outstanding` is the registered count before any same-cycle retirement.
- Address check on grant: in range iff `BaseAddr ≤ addr_i < BaseAddr+MemSizeBytes`. The word index is `(addr_i-BaseAddr)>>2`.
- Granted write, in range, `wdata_intg_i` equal to the encoding of `wdata_i`:
  - Each byte lane k with `be_i[k]` is written at the grant clock edge.
  - Response has `err_o=0` and `rdata_o=0`.
- Granted write, out of range or integrity mismatch: no array update, error response.
- Granted read, in range: the array word is sampled at the grant edge. `be_i` is ignored for reads and the full word is returned.
- Granted read, out of range: error response with `rdata_o=0`.
- `rdata_intg_o` always equals the encoding of the presented `rdata_o`, including zero data on errors and writes.
- Response pipeline: a shift register `RespLatency` deep carries {valid, err, rdata}.
  - Grants are accepted at most one per cycle, so responses leave strictly in grant order.
- Outstanding counter: +1 on grant, −1 on a `rvalid_o` cycle; both in the same cycle leaves it unchanged. It never exceeds `MaxOutstanding` and never goes negative.
- Ordering: a read granted in any cycle after a write's grant cycle returns the written data.
- Array contents are not reset; reads of never-written words return X in simulation.

## Timing
- Grant in cycle N produces `rvalid_o=1` in cycle N+`RespLatency` for exactly one cycle.
- Back-to-back grants give back-to-back `rvalid_o` pulses.
- `gnt_o` may assert in the same cycle `req_i` rises (zero-cycle grant). Request fields are sampled only in the grant cycle.
- `req_i` held high without a grant is legal; nothing is sampled until `gnt_o`.
- Reset values:
  - `rvalid_o=0`, `err_o=0`, `rdata_o=0`, `rdata_intg_o` = encoding of 0.
  - Outstanding count = 0, all pipeline stages invalid.
  - `gnt_o` follows its equation with count 0.
- Reset asserted mid-operation discards all in-flight responses; no `rvalid_o` appears for them after release. A write whose grant edge preceded reset assertion stays in the array.
- Limit case: with `MaxOutstanding=RespLatency+1`, full throughput is one grant per cycle with no bubbles. Smaller values insert grant stalls.

## Test plan
- Basic write then read: write 32'hDEADBEEF with `be_i`=4'hF to `BaseAddr`+4, then read the same address. Read has `rvalid_o` exactly `RespLatency` cycles after grant, `rdata_o`=32'hDEADBEEF, `rdata_intg_o` equal to the reference encoder output, `err_o`=0.
- Byte masking: write 32'h11223344 with be 4'hF, then 32'hAABBCCDD with be 4'b0101. Read returns 32'h11BB33DD.
- Errors:
  - Read of `BaseAddr`+`MemSizeBytes` gives `err_o`=1 and `rdata_o`=0.
  - Write with `wdata_intg_i` bit 0 flipped gives `err_o`=1, and a following read shows the word unchanged.
- Throughput and back-pressure:
  - `RespLatency`=2, `MaxOutstanding`=2, `req_i` held high for 6 reads: `gnt_o` alternates 2-on/1-off, every grant gets one in-order `rvalid_o`, and the count never exceeds 2.
  - With `MaxOutstanding`=3: 6 consecutive grants and 6 consecutive `rvalid_o` pulses.
- Stall: `stall_i`=1 for 5 cycles with `req_i`=1 gives `gnt_o`=0 throughout. Grant occurs in the cycle `stall_i` drops.
- Reset mid-flight: grant a read, assert `rst_ni` low before its response. No `rvalid_o` after release, all outputs at reset values, and a new read completes normally.
